piso_tx_scheduler: RTL and testbench

- Sequences a shared WIDTH-bit parallel-in/serial-out shift register and arbitrates its use between two requesters.
- Accepts a word from one requester over a valid/ready handshake, then drives the register's load and parallel_in pins.
- Times the WIDTH shift cycles, then inserts a programmable inter-frame gap.
- Sits between producer logic and the PISO. The PISO loads on any clock edge where load=1, otherwise shifts MSB-first, and serial_out shows the MSB in the cycle after the load edge.

---
 rtl/piso_tx_scheduler.sv | 105 ++++++++++
 tb/tb_piso_tx_scheduler.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/piso_tx_scheduler.sv
// rtl/piso_tx_scheduler.sv - two-requester round-robin scheduler driving a shared PISO shift register
// Frame: accept in IDLE, one LOAD cycle, WIDTH SHIFT cycles, then GAP_CYCLES idle cycles.
module piso_tx_scheduler #(
  parameter int WIDTH      = 4,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             piso_load,
  output logic [WIDTH-1:0] piso_data,
  output logic             tx_active,
  output logic             tx_owner,
  output logic             frame_done
);

  localparam int BW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_e;

  state_e           state_q, state_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [GW-1:0]    gap_cnt_q, gap_cnt_d;
  logic             last_grant_q, last_grant_d;
  logic [WIDTH-1:0] piso_data_q, piso_data_d;
  logic             tx_owner_q, tx_owner_d;
  logic             grant0, grant1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      gap_cnt_q    <= '0;
      last_grant_q <= 1'b1;
      piso_data_q  <= '0;
      tx_owner_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      gap_cnt_q    <= gap_cnt_d;
      last_grant_q <= last_grant_d;
      piso_data_q  <= piso_data_d;
      tx_owner_q   <= tx_owner_d;
    end
  end

  // On a tie the requester that did not win last time is granted.
  assign grant0 = req0_valid && (!req1_valid || last_grant_q);
  assign grant1 = req1_valid && (!req0_valid || !last_grant_q);

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    gap_cnt_d    = gap_cnt_q;
    last_grant_d = last_grant_q;
    piso_data_d  = piso_data_q;
    tx_owner_d   = tx_owner_q;
    req0_ready   = 1'b0;
    req1_ready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        req0_ready = grant0;
        req1_ready = grant1;
        if (grant0 || grant1) begin
          state_d      = S_LOAD;
          piso_data_d  = grant1 ? req1_data : req0_data;
          tx_owner_d   = grant1;
          last_grant_d = grant1;
        end
      end
      S_LOAD: begin
        state_d   = S_SHIFT;
        bit_cnt_d = '0;
      end
      S_SHIFT: begin
        if (bit_cnt_q == BIT_LAST) begin
          state_d   = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          gap_cnt_d = '0;
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) state_d = S_IDLE;
        else gap_cnt_d = gap_cnt_q + GW'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign piso_load  = (state_q == S_LOAD);
  assign tx_active  = (state_q == S_SHIFT);
  assign frame_done = (state_q == S_SHIFT) && (bit_cnt_q == BIT_LAST);
  assign piso_data  = piso_data_q;
  assign tx_owner   = tx_owner_q;

endmodule

// File: tb/tb_piso_tx_scheduler.sv
// tb/tb_piso_tx_scheduler.sv - randomized bench for piso_tx_scheduler against a frame-timeline model
// Two instances (GAP_CYCLES 0 and 1) share clock, reset and stimulus mode.
module tb_piso_tx_scheduler;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   mode = 0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : gi
    localparam int GAP = g;

    logic         v0 = 1'b0, v1 = 1'b0;
    logic [W-1:0] d0 = '0, d1 = '0;
    logic         r0, r1, ld, act, done, own;
    logic [W-1:0] pd;

    piso_tx_scheduler #(.WIDTH(W), .GAP_CYCLES(GAP)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(v0), .req0_data(d0), .req0_ready(r0),
      .req1_valid(v1), .req1_data(d1), .req1_ready(r1),
      .piso_load(ld), .piso_data(pd), .tx_active(act),
      .tx_owner(own), .frame_done(done)
    );

    // Model: each accepted frame occupies a fixed window on a cycle timeline.
    int           cyc, free_at, acc;
    bit           have, lg, own_m, a0, a1;
    bit [W-1:0]   acc_d;
    bit           pend, pend_own, once;
    bit [W-1:0]   pend_d;
    logic         ld_s;
    logic [W-1:0] pd_s, sr;

    always @(negedge clk) begin
      bit idle, g0, g1, e_ld, e_act, e_done;
      int k;
      ld_s = ld;
      pd_s = pd;
      if (!rst_n) begin
        check_eq($sformatf("g%0d rst load", g), ld, 0);
        check_eq($sformatf("g%0d rst active", g), act, 0);
        check_eq($sformatf("g%0d rst done", g), done, 0);
        check_eq($sformatf("g%0d rst data", g), pd, 0);
        check_eq($sformatf("g%0d rst owner", g), own, 0);
        pend = 1'b0;
      end else begin
        idle   = (cyc >= free_at);
        g0     = idle && v0 && (!v1 || lg);
        g1     = idle && v1 && (!v0 || !lg);
        e_ld   = have && (cyc == acc + 1);
        e_act  = have && (cyc >= acc + 2) && (cyc <= acc + 1 + W);
        e_done = have && (cyc == acc + 1 + W);
        check_eq($sformatf("g%0d ready0 c%0d", g, cyc), r0, g0);
        check_eq($sformatf("g%0d ready1 c%0d", g, cyc), r1, g1);
        check_eq($sformatf("g%0d load c%0d", g, cyc), ld, e_ld);
        check_eq($sformatf("g%0d active c%0d", g, cyc), act, e_act);
        check_eq($sformatf("g%0d done c%0d", g, cyc), done, e_done);
        check_eq($sformatf("g%0d data c%0d", g, cyc), pd, acc_d);
        check_eq($sformatf("g%0d owner c%0d", g, cyc), own, own_m);
        if (e_act) begin
          k = cyc - acc - 2;
          check_eq($sformatf("g%0d serial c%0d", g, cyc), sr[W-1], acc_d[W-1-k]);
        end
        pend     = g0 || g1;
        pend_own = g1;
        pend_d   = g1 ? d1 : d0;
      end
    end

    always @(posedge clk) sr <= ld_s ? pd_s : {sr[W-2:0], 1'b0};

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cyc <= 0; free_at <= 0; have <= 1'b0; lg <= 1'b1;
        own_m <= 1'b0; acc_d <= '0; a0 <= 1'b0; a1 <= 1'b0;
      end else begin
        a0 <= pend && !pend_own;
        a1 <= pend && pend_own;
        if (pend) begin
          acc     <= cyc;
          acc_d   <= pend_d;
          own_m   <= pend_own;
          lg      <= pend_own;
          have    <= 1'b1;
          free_at <= cyc + W + 2 + GAP;
        end
        cyc <= cyc + 1;
      end
    end

    always @(posedge clk) begin
      #2;
      case (mode)
        1: begin
          if (a0) once = 1'b1;
          v0 = !once && !a0;
          d0 = 4'b1011;
          v1 = 1'b0;
        end
        2: begin
          v0 = 1'b1; v1 = 1'b1; d0 = 4'b1100; d1 = 4'b0011;
        end
        3: begin
          if (a0) begin v0 = 1'($urandom_range(0, 1)); d0 = W'($urandom); end
          else if (!v0) begin if ($urandom_range(0, 3) == 0) begin v0 = 1'b1; d0 = W'($urandom); end end
          else if ($urandom_range(0, 7) == 0) v0 = 1'b0;
          if (a1) begin v1 = 1'($urandom_range(0, 1)); d1 = W'($urandom); end
          else if (!v1) begin if ($urandom_range(0, 3) == 0) begin v1 = 1'b1; d1 = W'($urandom); end end
          else if ($urandom_range(0, 7) == 0) v1 = 1'b0;
        end
        4: begin
          if (a0) d0 = (d0 == 4'hF) ? 4'h0 : 4'hF;
          else if (d0 != 4'hF && d0 != 4'h0) d0 = 4'hF;
          v0 = 1'b1;
          v1 = 1'b0;
        end
        default: begin
          v0 = 1'b0; v1 = 1'b0;
        end
      endcase
    end
  end

  initial begin
    bit found;
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    mode = 1; repeat (20) @(posedge clk);
    mode = 2; repeat (40) @(posedge clk);
    mode = 4; repeat (30) @(posedge clk);
    mode = 3; repeat (300) @(posedge clk);

    mode = 2;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (gi[1].act && gi[1].cyc == gi[1].acc + 4) found = 1'b1;
    end
    check_eq("mid_reset_reached_bit2", found, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async g1 active", gi[1].act, 0);
    check_eq("async g1 load", gi[1].ld, 0);
    check_eq("async g1 done", gi[1].done, 0);
    check_eq("async g0 active", gi[0].act, 0);
    check_eq("async g0 load", gi[0].ld, 0);
    check_eq("async g0 done", gi[0].done, 0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    repeat (40) @(posedge clk);
    mode = 3; repeat (300) @(posedge clk);
    mode = 0; repeat (10) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
